// File: rtl/cfg_serializer_pkg.sv
// Shared widths, frame length and FSM encoding for the gain-configuration serializer.
package cfg_pkg;

    localparam int W_A1  = 2;
    localparam int W_A2  = 3;
    localparam int NB    = W_A1 + W_A2;
    localparam int CNT_W = $clog2(NB + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Frame image: gainA1 occupies the low bits so it leaves first, LSB-first.
    function automatic logic [NB-1:0] pack_frame(input logic [W_A1-1:0] a1,
                                                 input logic [W_A2-1:0] a2);
        return {a2, a1};
    endfunction

endpackage

// File: rtl/cfg_serializer_if.sv
// Request/gain inputs and serial/status outputs of the serializer.
interface cfg_serializer_if;
    import cfg_pkg::*;

    logic            i_start;
    logic [W_A1-1:0] i_gainA1;
    logic [W_A2-1:0] i_gainA2;
    logic            o_sclk;
    logic            o_sdin;
    logic            o_busy;
    logic            o_done;

    modport master (
        output i_start, i_gainA1, i_gainA2,
        input  o_sclk, o_sdin, o_busy, o_done
    );

    modport slave (
        input  i_start, i_gainA1, i_gainA2,
        output o_sclk, o_sdin, o_busy, o_done
    );

endinterface

// File: rtl/cfg_serializer_sclk_gen.sv
// Half-period timer for the serial clock: strobes once every SCLK_DIV enabled cycles.
module cfg_sclk_gen #(
    parameter int SCLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_resetbAll,
    input  logic i_en,
    input  logic i_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int PH_W = $clog2(SCLK_DIV + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SCLK_DIV - 1);

    logic [PH_W-1:0] r_phase;
    logic            w_tick;

    assign w_tick = i_en && (r_phase == PH_LAST);
    assign o_rise = w_tick && !i_sclk;
    assign o_fall = w_tick && i_sclk;

    // Phase counter: restarts at every strobe and is held at zero while idle.
    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            r_phase <= '0;
        end else if (!i_en || w_tick) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + PH_W'(1);
        end
    end

endmodule

// File: rtl/cfg_serializer.sv
// Serializes {gainA2, gainA1} LSB-first onto a register-driven o_sclk/o_sdin pair.
module cfg_serializer
    import cfg_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic            i_clk,
    input  logic            i_resetbAll,
    cfg_serializer_if.slave io_bus
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NB - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [NB-1:0]    r_shift;
    logic [NB-1:0]    w_shift_nxt;
    logic [NB-1:0]    w_frame;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic             r_sclk;
    logic             w_sclk_nxt;
    logic             r_sdin;
    logic             w_sdin_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_rise;
    logic             w_fall;

    assign w_frame = pack_frame(io_bus.i_gainA1, io_bus.i_gainA2);

    cfg_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .i_clk       (i_clk),
        .i_resetbAll (i_resetbAll),
        .i_en        (r_busy),
        .i_sclk      (r_sclk),
        .o_rise      (w_rise),
        .o_fall      (w_fall)
    );

    // State and output registers; reset aborts any frame without a done pulse.
    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_sdin    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_sclk    <= w_sclk_nxt;
            r_sdin    <= w_sdin_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state and next-output logic; DONE accepts a new start so frames can abut.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_sclk_nxt    = r_sclk;
        w_sdin_nxt    = r_sdin;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (io_bus.i_start) begin
                    w_state_nxt   = ST_LOW;
                    w_shift_nxt   = w_frame;
                    w_bit_cnt_nxt = '0;
                    w_sclk_nxt    = 1'b0;
                    w_sdin_nxt    = w_frame[0];
                    w_busy_nxt    = 1'b1;
                end else begin
                    w_state_nxt   = ST_IDLE;
                    w_sclk_nxt    = 1'b0;
                    w_sdin_nxt    = 1'b0;
                    w_busy_nxt    = 1'b0;
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                    w_sclk_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (w_fall) begin
                    w_sclk_nxt = 1'b0;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = ST_DONE;
                        w_sdin_nxt  = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = ST_LOW;
                        w_shift_nxt   = r_shift >> 1;
                        w_sdin_nxt    = w_shift_nxt[0];
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end else begin
                    w_state_nxt = ST_HIGH;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_shift_nxt   = '0;
                w_bit_cnt_nxt = '0;
                w_sclk_nxt    = 1'b0;
                w_sdin_nxt    = 1'b0;
                w_busy_nxt    = 1'b0;
            end
        endcase
    end

    assign io_bus.o_sclk = r_sclk;
    assign io_bus.o_sdin = r_sdin;
    assign io_bus.o_busy = r_busy;
    assign io_bus.o_done = r_done;

endmodule
